// File: rtl/tile_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tile_ram_arbiter                                                 |
// | Purpose : Single-port owner of the 16x8 tile-board RAM. Arbitrates between |
// |           the game FSM (read/write) and the VGA renderer (read-only), and  |
// |           contains a board loader that shuffles 8 tile pairs and writes    |
// |           all 16 words.                                                    |
// | Config  : ARB_RDATA_REG_EN - register g_rdata/v_rdata (rvalid 2 cycles     |
// |           after gnt) instead of a gated passthrough (rvalid 1 cycle after).|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tile_ram_arbiter #(
  parameter int unsigned VGA_MAX_WAIT = 4,
  parameter logic [7:0]  LFSR_TAPS    = 8'hB8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] seed,
  input  logic       init_start,
  output logic       init_busy,
  output logic       init_done,
  input  logic       g_req,
  input  logic       g_we,
  input  logic [3:0] g_addr,
  input  logic [7:0] g_wdata,
  output logic       g_gnt,
  output logic       g_rvalid,
  output logic [7:0] g_rdata,
  input  logic       v_req,
  input  logic [3:0] v_addr,
  output logic       v_gnt,
  output logic       v_rvalid,
  output logic [7:0] v_rdata,
  output logic [3:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHUFFLE = 2'd1,
    ST_WRITE   = 2'd2
  } loadState_t;

  localparam logic [3:0] c_MAX_WAIT = 4'(VGA_MAX_WAIT);

  loadState_t r_state;
  loadState_t w_stateNext;

  logic [7:0] r_lfsr;
  logic [3:0] r_idx;          // shuffle position i, counts 15 down to 1
  logic [4:0] r_wrCnt;        // write address; bit 4 marks the finishing step
  logic [2:0] r_shadow [16];  // shuffled pair ids before they reach the RAM
  logic [3:0] r_waitCnt;

  logic       r_gGnt;
  logic       r_vGnt;
  logic       r_ramWe;
  logic [3:0] r_ramAddr;
  logic [7:0] r_ramWdata;
  logic       r_busy;
  logic       r_done;
  logic       r_gRd1;         // game read data is on ram_rdata this cycle
  logic       r_vRd1;         // VGA read data is on ram_rdata this cycle

  logic       w_start;
  logic       w_swap;
  logic       w_write;
  logic       w_finish;
  logic [3:0] w_mask;
  logic [3:0] w_j;
  logic       w_lfsrFb;
  logic       w_arbEn;
  logic       w_grantG;
  logic       w_grantV;

  // Smallest 2^n-1 covering i, so j is uniform over a tight range before rejection
  always_comb begin
    w_mask = 4'd1;
    if (r_idx >= 4'd8)      w_mask = 4'd15;
    else if (r_idx >= 4'd4) w_mask = 4'd7;
    else if (r_idx >= 4'd2) w_mask = 4'd3;
  end

  assign w_j      = r_lfsr[3:0] & w_mask;
  assign w_lfsrFb = ^(r_lfsr & LFSR_TAPS);

  // Loader next-state and step strobes
  always_comb begin
    w_stateNext = r_state;
    w_start     = 1'b0;
    w_swap      = 1'b0;
    w_write     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (init_start) begin
          w_start     = 1'b1;
          w_stateNext = ST_SHUFFLE;
        end
      end
      ST_SHUFFLE: begin
        if (w_j <= r_idx) begin
          w_swap = 1'b1;
          if (r_idx == 4'd1) w_stateNext = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (r_wrCnt[4]) begin
          w_finish    = 1'b1;
          w_stateNext = ST_IDLE;
        end else begin
          w_write = 1'b1;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Loader state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_stateNext;
  end

  // Requests are only arbitrated while the loader is idle and not being started;
  // VGA wins over the game once it has waited VGA_MAX_WAIT cycles
  assign w_arbEn  = (r_state == ST_IDLE) && !init_start;
  assign w_grantV = w_arbEn && v_req && (!g_req || (r_waitCnt == c_MAX_WAIT));
  assign w_grantG = w_arbEn && g_req && !w_grantV;

  // Loader datapath: LFSR, Fisher-Yates shuffle of the shadow ids, write address
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lfsr  <= 8'h01;
      r_idx   <= 4'd0;
      r_wrCnt <= 5'd0;
      for (int k = 0; k < 16; k++) r_shadow[k] <= 3'd0;
    end else if (w_start) begin
      r_lfsr  <= (seed == 8'h00) ? 8'h01 : seed;
      r_idx   <= 4'd15;
      r_wrCnt <= 5'd0;
      for (int k = 0; k < 16; k++) r_shadow[k] <= 3'(k >> 1);
    end else if (r_state == ST_SHUFFLE) begin
      r_lfsr <= {r_lfsr[6:0], w_lfsrFb};
      if (w_swap) begin
        r_shadow[r_idx] <= r_shadow[w_j];
        r_shadow[w_j]   <= r_shadow[r_idx];
        r_idx           <= r_idx - 4'd1;
      end
    end else if (w_write) begin
      r_wrCnt <= r_wrCnt + 5'd1;
    end
  end

  // VGA starvation counter; frozen whenever arbitration is suspended
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_waitCnt <= 4'd0;
    end else if (w_arbEn) begin
      if (!v_req || w_grantV)          r_waitCnt <= 4'd0;
      else if (r_waitCnt != c_MAX_WAIT) r_waitCnt <= r_waitCnt + 4'd1;
    end
  end

  // Registered RAM port, grants and loader status
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gGnt     <= 1'b0;
      r_vGnt     <= 1'b0;
      r_ramWe    <= 1'b0;
      r_ramAddr  <= 4'd0;
      r_ramWdata <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_gRd1     <= 1'b0;
      r_vRd1     <= 1'b0;
    end else begin
      r_gGnt  <= w_grantG;
      r_vGnt  <= w_grantV;
      r_ramWe <= 1'b0;
      r_done  <= w_finish;
      if (w_start)       r_busy <= 1'b1;
      else if (w_finish) r_busy <= 1'b0;
      if (w_write) begin
        r_ramWe    <= 1'b1;
        r_ramAddr  <= r_wrCnt[3:0];
        r_ramWdata <= {3'b000, r_shadow[r_wrCnt[3:0]], 1'b0, (r_wrCnt == 5'd0)};
      end else if (w_grantG) begin
        r_ramWe    <= g_we;
        r_ramAddr  <= g_addr;
        r_ramWdata <= g_wdata;
      end else if (w_grantV) begin
        r_ramAddr <= v_addr;
      end
      r_gRd1 <= r_gGnt & ~r_ramWe;
      r_vRd1 <= r_vGnt;
    end
  end

  assign g_gnt     = r_gGnt;
  assign v_gnt     = r_vGnt;
  assign ram_we    = r_ramWe;
  assign ram_addr  = r_ramAddr;
  assign ram_wdata = r_ramWdata;
  assign init_busy = r_busy;
  assign init_done = r_done;

`ifdef ARB_RDATA_REG_EN
  logic       r_gRvalid;
  logic       r_vRvalid;
  logic [7:0] r_gRdata;
  logic [7:0] r_vRdata;

  // Capture RAM data one cycle after it appears; data holds until the next read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gRvalid <= 1'b0;
      r_vRvalid <= 1'b0;
      r_gRdata  <= 8'd0;
      r_vRdata  <= 8'd0;
    end else begin
      r_gRvalid <= r_gRd1;
      r_vRvalid <= r_vRd1;
      if (r_gRd1) r_gRdata <= ram_rdata;
      if (r_vRd1) r_vRdata <= ram_rdata;
    end
  end

  assign g_rvalid = r_gRvalid;
  assign v_rvalid = r_vRvalid;
  assign g_rdata  = r_gRdata;
  assign v_rdata  = r_vRdata;
`else
  // Passthrough gated by rvalid so idle outputs read as zero
  assign g_rvalid = r_gRd1;
  assign v_rvalid = r_vRd1;
  assign g_rdata  = r_gRd1 ? ram_rdata : 8'h00;
  assign v_rdata  = r_vRd1 ? ram_rdata : 8'h00;
`endif

endmodule
`default_nettype wire
